uart_tx_sched: RTL and testbench



---
 rtl/uart_tx_sched.sv | 127 ++++++++++++
 tb/tb_uart_tx_sched.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: shared UART transmitter. Round-robin arbitration among
// N_REQ byte producers, then an 8N1 frame on o_tx at CLKS_PER_BIT clocks per bit.
//
// Ports:
//   i_clk    system clock (rising edge)
//   i_rst_n  asynchronous active-low reset
//   i_valid  per-requester byte valid
//   i_data   packed bytes, requester k on [8k+7:8k]
//   o_ready  one-hot accept strobe, only while idle; a byte moves on valid&ready
//   o_tx     serial line, idles high
//   o_busy   frame in progress
//   o_owner  requester whose frame is (or was last) on the line
module uart_tx_sched #(
  parameter int N_REQ        = 2,
  parameter int CLKS_PER_BIT = 16,
  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int CW = $clog2(CLKS_PER_BIT)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [N_REQ-1:0]   i_valid,
  input  logic [8*N_REQ-1:0] i_data,
  output logic [N_REQ-1:0]   o_ready,
  output logic               o_tx,
  output logic               o_busy,
  output logic [OW-1:0]      o_owner
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                  state, state_d;
  logic [CW-1:0]           cnt;
  logic [2:0]              bit_idx;
  logic [7:0]              shift;
  logic [OW-1:0]           last;
  logic [OW-1:0]           owner;

  logic [N_REQ-1:0][7:0]   req_data;
  logic [N_REQ-1:0]        gnt;
  logic [OW-1:0]           gnt_idx;
  logic [7:0]              gnt_data;
  logic                    found;
  logic                    accept;
  logic                    bit_end;

  assign req_data = i_data;
  assign bit_end  = (cnt == CW'(CLKS_PER_BIT - 1));

  // Round-robin search starting one past the last winner, wrapping. The
  // first hit wins, so exactly one requester is granted per idle cycle.
  always_comb begin
    int k;
    k        = 0;
    gnt      = '0;
    gnt_idx  = '0;
    gnt_data = '0;
    found    = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      k = (int'(last) + 1 + i) % N_REQ;
      if (!found && i_valid[k]) begin
        found    = 1'b1;
        gnt[k]   = 1'b1;
        gnt_idx  = OW'(k);
        gnt_data = req_data[k];
      end
    end
  end

  assign accept  = (state == IDLE) && found;
  assign o_ready = (state == IDLE) ? gnt : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (accept) state_d = START;
      START:   if (bit_end) state_d = DATA;
      DATA:    if (bit_end && bit_idx == 3'd7) state_d = STOP;
      STOP:    if (bit_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bit-period counter, bit index, shift register and grant history.
  // last resets to N_REQ-1 so requester 0 wins the first tie.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      last    <= OW'(N_REQ - 1);
      owner   <= '0;
    end else begin
      if (state == IDLE || bit_end) cnt <= '0;
      else                          cnt <= cnt + 1'b1;

      if (accept) begin
        shift   <= gnt_data;
        last    <= gnt_idx;
        owner   <= gnt_idx;
        bit_idx <= '0;
      end else if (state == DATA && bit_end) begin
        // bit_idx wraps 7->0 on the last data bit, ready for the next frame
        shift   <= {1'b0, shift[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

  // Line driven straight from state so an async reset idles it at once.
  always_comb begin
    o_tx = 1'b1;
    case (state)
      START:   o_tx = 1'b0;
      DATA:    o_tx = shift[0];
      default: o_tx = 1'b1;
    endcase
  end

  assign o_busy  = (state != IDLE);
  assign o_owner = owner;

endmodule

// File: tb/tb_uart_tx_sched.sv
module tb_uart_tx_sched;

  localparam int C = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  valid;
  logic [23:0] data;
  logic [2:0]  ready;
  logic        tx, busy;
  logic [1:0]  owner;

  logic        valid1;
  logic [7:0]  data1;
  logic        ready1, tx1, busy1;
  logic        owner1;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  uart_tx_sched #(.N_REQ(3), .CLKS_PER_BIT(C)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_data(data),
    .o_ready(ready), .o_tx(tx), .o_busy(busy), .o_owner(owner)
  );

  uart_tx_sched #(.N_REQ(1), .CLKS_PER_BIT(16)) dut16 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid1), .i_data(data1),
    .o_ready(ready1), .o_tx(tx1), .o_busy(busy1), .o_owner(owner1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected line for one frame at C=4, index 0 = first cycle after accept.
  function automatic logic [39:0] exp_frame(input logic [7:0] b);
    logic [39:0] f;
    f = '1;
    for (int j = 0; j < 4; j++) f[j] = 1'b0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 4; j++) f[4 + 4*i + j] = b[i];
    return f;
  endfunction

  task automatic do_reset();
    valid  = '0;
    valid1 = 1'b0;
    rst_n  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Waits (bounded) for a valid&ready cycle; returns winner and cycle stamp.
  task automatic wait_grant(output int k, output bit ok, output int t);
    k = -1; ok = 1'b0; t = 0;
    for (int n = 0; n < 400; n++) begin
      #1;
      if (|(valid & ready)) begin
        for (int j = 0; j < 3; j++) if (valid[j] & ready[j]) k = j;
        ok = 1'b1;
        t  = cyc;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      vectors++; errors++;
      $display("FAIL grant_timeout: no accept within 400 cycles, want one");
    end
  endtask

  // Captures 40 frame cycles following the accept edge.
  task automatic grab(output logic [39:0] txs, output int bcnt, output int rcnt,
                      output logic [1:0] own);
    bcnt = 0; rcnt = 0; own = '0; txs = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      txs[i] = tx;
      if (busy) bcnt++;
      if (|ready) rcnt++;
      if (i == 0) own = owner;
    end
  endtask

  task automatic test_reset();
    valid = '0; valid1 = 1'b0; data = '0; data1 = '0;
    rst_n = 1'b0;
    #1;
    vectors++; if (tx !== 1'b1)    begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
    vectors++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (ready !== 3'b0) begin errors++; $display("FAIL reset_ready: got %b want 000", ready); end
    vectors++; if (owner !== 2'd0) begin errors++; $display("FAIL reset_owner: got %0d want 0", owner); end
    vectors++; if (tx1 !== 1'b1)   begin errors++; $display("FAIL reset_tx16: got %b want 1", tx1); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    valid = 3'b111;
    #1;
    vectors++; if (ready !== 3'b001) begin errors++; $display("FAIL reset_first_tie: got %b want 001", ready); end
    valid = 3'b000;
    #1;
    vectors++; if (ready !== 3'b000) begin errors++; $display("FAIL idle_no_valid: got %b want 000", ready); end
  endtask

  task automatic test_single();
    int k, t, b, r; bit ok; logic [39:0] f; logic [1:0] o;
    do_reset();
    data[7:0] = 8'h55; valid = 3'b001;
    wait_grant(k, ok, t);
    if (!ok) return;
    vectors++; if (k != 0) begin errors++; $display("FAIL single_grant: got %0d want 0", k); end
    @(posedge clk); #1 valid = '0;
    grab(f, b, r, o);
    vectors++; if (f !== exp_frame(8'h55)) begin errors++; $display("FAIL single_frame: got %h want %h", f, exp_frame(8'h55)); end
    vectors++; if (b != 40) begin errors++; $display("FAIL single_busy: got %0d want 40", b); end
    vectors++; if (r != 0)  begin errors++; $display("FAIL single_ready_midframe: got %0d want 0", r); end
    vectors++; if (o !== 2'd0) begin errors++; $display("FAIL single_owner: got %0d want 0", o); end
    @(negedge clk);
    vectors++; if (busy !== 1'b0 || tx !== 1'b1) begin errors++; $display("FAIL single_idle_after: got busy=%b tx=%b want 0 1", busy, tx); end
  endtask

  task automatic test_contention();
    int k, t, pt, b, r; bit ok; logic [39:0] f; logic [1:0] o;
    int rem [2];
    int ek [4];
    logic [7:0] eb;
    rem = '{2, 2};
    ek  = '{0, 1, 0, 1};
    pt  = 0;
    do_reset();
    data = {8'h00, 8'h42, 8'h41}; valid = 3'b011;
    for (int n = 0; n < 4; n++) begin
      wait_grant(k, ok, t);
      if (!ok) break;
      vectors++; if (k != ek[n]) begin errors++; $display("FAIL contention_order%0d: got %0d want %0d", n, k, ek[n]); end
      if (n > 0) begin
        vectors++; if (t - pt != 10*C + 1) begin errors++; $display("FAIL contention_spacing%0d: got %0d want %0d", n, t - pt, 10*C + 1); end
      end
      pt = t;
      @(posedge clk); #1;
      if (k == 0 || k == 1) begin
        rem[k]--;
        if (rem[k] == 0) valid[k] = 1'b0;
      end
      grab(f, b, r, o);
      eb = (ek[n] == 1) ? 8'h42 : 8'h41;
      vectors++; if (f !== exp_frame(eb)) begin errors++; $display("FAIL contention_frame%0d: got %h want %h", n, f, exp_frame(eb)); end
      vectors++; if (o !== 2'(ek[n])) begin errors++; $display("FAIL contention_owner%0d: got %0d want %0d", n, o, ek[n]); end
    end
    valid = '0;
  endtask

  task automatic test_rotation();
    int k, t, b, r; bit ok; logic [39:0] f; logic [1:0] o;
    int ek [7];
    ek = '{0, 2, 0, 2, 0, 1, 2};
    do_reset();
    data = {8'h12, 8'h11, 8'h10}; valid = 3'b101;
    for (int n = 0; n < 7; n++) begin
      wait_grant(k, ok, t);
      if (!ok) break;
      vectors++; if (k != ek[n]) begin errors++; $display("FAIL rotation_grant%0d: got %0d want %0d", n, k, ek[n]); end
      @(posedge clk); #1;
      if (n == 4) valid[1] = 1'b1;
      if (n == 5) valid[1] = 1'b0;
      grab(f, b, r, o);
      vectors++; if (f !== exp_frame(8'h10 + 8'(ek[n]))) begin errors++; $display("FAIL rotation_frame%0d: got %h want %h", n, f, exp_frame(8'h10 + 8'(ek[n]))); end
    end
    valid = '0;
    @(negedge clk);
  endtask

  task automatic test_withdrawal();
    int k, t, bad; bit ok;
    do_reset();
    data[7:0] = 8'h33; valid = 3'b001;
    wait_grant(k, ok, t);
    if (!ok) return;
    @(posedge clk); #1 valid = '0;
    repeat (10) @(negedge clk);
    data[15:8] = 8'h77; valid[1] = 1'b1;
    repeat (20) @(negedge clk);
    valid[1] = 1'b0;
    repeat (15) @(negedge clk);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (ready !== 3'b000 || tx !== 1'b1 || busy !== 1'b0) bad++;
      @(negedge clk);
    end
    vectors++; if (bad != 0) begin errors++; $display("FAIL withdrawal_idle: got %0d bad cycles want 0", bad); end
    vectors++; if (owner !== 2'd0) begin errors++; $display("FAIL withdrawal_owner: got %0d want 0", owner); end
  endtask

  task automatic test_reset_mid();
    int k, t, b, r; bit ok; logic [39:0] f; logic [1:0] o;
    do_reset();
    data[7:0] = 8'h00; valid = 3'b001;
    wait_grant(k, ok, t);
    if (!ok) return;
    @(posedge clk); #1 valid = '0;
    repeat (18) @(negedge clk);
    vectors++; if (tx !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL resetmid_bit3: got tx=%b busy=%b want 0 1", tx, busy); end
    #1 rst_n = 1'b0;
    #1;
    vectors++; if (tx !== 1'b1)   begin errors++; $display("FAIL resetmid_tx: got %b want 1", tx); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL resetmid_busy: got %b want 0", busy); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    data[15:8] = 8'hA5; valid = 3'b010;
    wait_grant(k, ok, t);
    if (!ok) return;
    vectors++; if (k != 1) begin errors++; $display("FAIL resetmid_grant: got %0d want 1", k); end
    @(posedge clk); #1 valid = '0;
    grab(f, b, r, o);
    vectors++; if (f !== exp_frame(8'hA5)) begin errors++; $display("FAIL resetmid_frame: got %h want %h", f, exp_frame(8'hA5)); end
    vectors++; if (o !== 2'd1) begin errors++; $display("FAIL resetmid_owner: got %0d want 1", o); end
    vectors++; if (b != 40)    begin errors++; $display("FAIL resetmid_busy_len: got %0d want 40", b); end
  endtask

  // Mid-bit sampling receiver on the C=16, single-requester instance.
  task automatic test_ramp();
    bit ok, seen;
    logic [9:0] rx;
    do_reset();
    for (int b = 0; b < 256; b++) begin
      data1 = 8'(b); valid1 = 1'b1;
      ok = 1'b0;
      for (int n = 0; n < 400; n++) begin
        #1;
        if (valid1 & ready1) begin ok = 1'b1; break; end
        @(negedge clk);
      end
      if (!ok) begin
        vectors++; errors++;
        $display("FAIL ramp_timeout: byte %0d not accepted", b);
        break;
      end
      @(posedge clk); #1 valid1 = 1'b0;
      seen = 1'b0;
      for (int n = 0; n < 20; n++) begin
        @(negedge clk);
        if (tx1 === 1'b0) begin seen = 1'b1; break; end
      end
      rx = '1;
      if (seen) begin
        repeat (7) @(negedge clk);
        rx[0] = tx1;
        for (int j = 1; j < 10; j++) begin
          repeat (16) @(negedge clk);
          rx[j] = tx1;
        end
      end
      vectors++;
      if (rx !== {1'b1, 8'(b), 1'b0}) begin
        errors++;
        $display("FAIL ramp_byte%0d: got frame %b want %b", b, rx, {1'b1, 8'(b), 1'b0});
      end
    end
    vectors++; if (owner1 !== 1'b0) begin errors++; $display("FAIL ramp_owner: got %b want 0", owner1); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_rotation();
    test_withdrawal();
    test_reset_mid();
    test_ramp();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
